// File: rtl/degree_counter_table.sv
// Per-node in-degree table for Kahn's topological sort: one dual-port RAM of counts, with the
// increment port fed by edge parsing and the decrement port by the sort engine.
module degree_counter_table #(
    parameter int unsigned MAX_NODES  = 1024,
    parameter int unsigned NODE_WIDTH = $clog2(MAX_NODES),
    parameter int unsigned CNT_WIDTH  = NODE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_start,
    output logic                  ready,
    input  logic                  inc_valid,
    input  logic [NODE_WIDTH-1:0] inc_node,
    input  logic                  dec_valid,
    input  logic [NODE_WIDTH-1:0] dec_node,
    output logic                  dec_out_valid,
    output logic [NODE_WIDTH-1:0] dec_out_node,
    output logic [CNT_WIDTH-1:0]  dec_out_degree,
    output logic                  dec_out_zero,
    output logic                  err_overflow,
    output logic                  err_underflow,
    output logic                  err_range
);
    localparam logic [CNT_WIDTH-1:0]  CntMax   = '1;
    localparam logic [NODE_WIDTH-1:0] LastNode = NODE_WIDTH'(MAX_NODES - 1);

    typedef enum logic [1:0] {StInit, StRun, StDrain} state_t;

    state_t                state;
    logic [NODE_WIDTH-1:0] init_addr;
    logic                  drain_last;
    logic                  init_entry;

    logic [CNT_WIDTH-1:0] mem [MAX_NODES];

    logic                  inc_acc, dec_acc, inc_in_rng, dec_in_rng;
    logic [NODE_WIDTH-1:0] inc_raddr, dec_raddr;

    logic                  s1_inc_valid, s1_inc_ok, s1_dec_valid, s1_dec_ok;
    logic [NODE_WIDTH-1:0] s1_inc_node, s1_dec_node;
    logic [CNT_WIDTH-1:0]  s1_inc_rdata, s1_dec_rdata;

    // Writes committed on the previous edge; a read issued on that same edge missed them.
    logic                  wb_inc_valid, wb_dec_valid;
    logic [NODE_WIDTH-1:0] wb_inc_node, wb_dec_node;
    logic [CNT_WIDTH-1:0]  wb_inc_data, wb_dec_data;

    logic                  same_node, inc_sat, dec_under, inc_wr, dec_wr, wa_en;
    logic [CNT_WIDTH-1:0]  inc_old, inc_new, dec_old, dec_new, wa_data;
    logic [NODE_WIDTH-1:0] wa_addr;

    assign init_entry = (state == StDrain) && drain_last;
    assign inc_in_rng = 32'(inc_node) < MAX_NODES;
    assign dec_in_rng = 32'(dec_node) < MAX_NODES;
    assign inc_acc    = inc_valid && ready;
    assign dec_acc    = dec_valid && ready;
    assign inc_raddr  = inc_in_rng ? inc_node : '0;
    assign dec_raddr  = dec_in_rng ? dec_node : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StInit;
            init_addr  <= '0;
            drain_last <= 1'b0;
            ready      <= 1'b0;
        end else begin
            unique case (state)
                StInit: begin
                    if (init_addr == LastNode) begin
                        state     <= StRun;
                        ready     <= 1'b1;
                        init_addr <= '0;
                    end else begin
                        init_addr <= init_addr + 1'b1;
                    end
                end
                StRun: begin
                    if (clear_start) begin
                        state      <= StDrain;
                        ready      <= 1'b0;
                        drain_last <= 1'b0;
                    end
                end
                StDrain: begin
                    drain_last <= 1'b1;
                    if (drain_last) state <= StInit;
                end
                default: begin
                    state <= StInit;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        inc_old = s1_inc_rdata;
        if (wb_dec_valid && wb_dec_node == s1_inc_node) inc_old = wb_dec_data;
        else if (wb_inc_valid && wb_inc_node == s1_inc_node) inc_old = wb_inc_data;
        inc_sat = (inc_old == CntMax);
        inc_new = inc_sat ? inc_old : inc_old + 1'b1;

        // Same-node inc/dec in one cycle: dec sees the incremented value, single write.
        same_node = s1_inc_valid && s1_inc_ok && s1_dec_valid && s1_dec_ok &&
                    (s1_inc_node == s1_dec_node);
        dec_old = s1_dec_rdata;
        if (same_node) dec_old = inc_new;
        else if (wb_dec_valid && wb_dec_node == s1_dec_node) dec_old = wb_dec_data;
        else if (wb_inc_valid && wb_inc_node == s1_dec_node) dec_old = wb_inc_data;
        dec_under = (dec_old == '0);
        dec_new   = dec_under ? '0 : dec_old - 1'b1;

        inc_wr  = s1_inc_valid && s1_inc_ok && !same_node;
        dec_wr  = s1_dec_valid && s1_dec_ok;
        wa_en   = inc_wr;
        wa_addr = s1_inc_node;
        wa_data = inc_new;
        if (state == StInit) begin
            wa_en   = 1'b1;
            wa_addr = init_addr;
            wa_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        s1_inc_rdata <= mem[inc_raddr];
        s1_dec_rdata <= mem[dec_raddr];
        if (wa_en) mem[wa_addr] <= wa_data;
        if (dec_wr) mem[s1_dec_node] <= dec_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_inc_valid   <= 1'b0;
            s1_inc_ok      <= 1'b0;
            s1_inc_node    <= '0;
            s1_dec_valid   <= 1'b0;
            s1_dec_ok      <= 1'b0;
            s1_dec_node    <= '0;
            wb_inc_valid   <= 1'b0;
            wb_inc_node    <= '0;
            wb_inc_data    <= '0;
            wb_dec_valid   <= 1'b0;
            wb_dec_node    <= '0;
            wb_dec_data    <= '0;
            dec_out_valid  <= 1'b0;
            dec_out_node   <= '0;
            dec_out_degree <= '0;
            dec_out_zero   <= 1'b0;
            err_overflow   <= 1'b0;
            err_underflow  <= 1'b0;
            err_range      <= 1'b0;
        end else begin
            s1_inc_valid  <= inc_acc;
            s1_inc_ok     <= inc_in_rng;
            s1_inc_node   <= inc_node;
            s1_dec_valid  <= dec_acc;
            s1_dec_ok     <= dec_in_rng;
            s1_dec_node   <= dec_node;
            wb_inc_valid  <= inc_wr;
            wb_inc_node   <= s1_inc_node;
            wb_inc_data   <= inc_new;
            wb_dec_valid  <= dec_wr;
            wb_dec_node   <= s1_dec_node;
            wb_dec_data   <= dec_new;
            dec_out_valid <= s1_dec_valid;
            if (s1_dec_valid) begin
                dec_out_node   <= s1_dec_node;
                dec_out_degree <= s1_dec_ok ? dec_new : '0;
                dec_out_zero   <= s1_dec_ok && (dec_new == '0);
            end
            if (init_entry) begin
                err_overflow  <= 1'b0;
                err_underflow <= 1'b0;
                err_range     <= 1'b0;
            end else begin
                err_overflow  <= err_overflow || (s1_inc_valid && s1_inc_ok && inc_sat);
                err_underflow <= err_underflow || (s1_dec_valid && s1_dec_ok && dec_under);
                err_range     <= err_range || (s1_inc_valid && !s1_inc_ok) ||
                                 (s1_dec_valid && !s1_dec_ok);
            end
        end
    end
endmodule
